// File: rtl/pool2d_gen.sv
// pool2d_gen: streaming per-column max/average pooling over WIN-element groups.
// Each accepted in_valid beat carries one window element for all COL columns.
// After WIN elements the pooled result is registered and pulsed on out_valid,
// tagged with the index of the group within an NGRP-group frame.
// Optional feature macro: POOL2D_GEN_RELU_EN clamps negative column results to
// zero before they reach out_data.
module pool2d_gen #(
  parameter int unsigned PSUM_BW = 16,
  parameter int unsigned COL     = 8,
  parameter int unsigned WIN     = 4,
  parameter int unsigned NGRP    = 4,
  localparam int unsigned GW     = (NGRP > 1) ? $clog2(NGRP) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [PSUM_BW*COL-1:0] in_data,
  input  logic                   mode,
  input  logic                   clear,
  output logic                   out_valid,
  output logic [PSUM_BW*COL-1:0] out_data,
  output logic [GW-1:0]          out_grp,
  output logic                   busy
);

  localparam int unsigned LW = $clog2(WIN);
  localparam int unsigned AW = PSUM_BW + LW;
  localparam int unsigned DW = PSUM_BW * COL;

  logic [LW-1:0] r_cnt;
  logic [GW-1:0] r_grp;
  logic          r_mode_q;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [GW-1:0] r_out_grp;
  logic          r_busy;

  logic          w_accept;
  logic          w_first;
  logic          w_last;
  logic [LW-1:0] w_cnt_next;
  logic [GW-1:0] w_grp_next;
  logic [DW-1:0] w_result;

  // An element is taken only when clear is not aborting the group.
  assign w_accept = in_valid & ~clear;
  assign w_first  = (r_cnt == '0);
  assign w_last   = (r_cnt == LW'(WIN - 1));

  // Element and group counter next-state; clear wins over a same-cycle element.
  always_comb begin
    w_cnt_next = r_cnt;
    w_grp_next = r_grp;
    if (clear) begin
      w_cnt_next = '0;
      w_grp_next = '0;
    end else if (in_valid) begin
      if (w_last) begin
        w_cnt_next = '0;
        w_grp_next = (r_grp == GW'(NGRP - 1)) ? '0 : r_grp + GW'(1);
      end else begin
        w_cnt_next = r_cnt + LW'(1);
      end
    end
  end

  // Per-column accumulator and pooled-result datapath.
  for (genvar c = 0; c < COL; c++) begin : g_col
    logic signed [PSUM_BW-1:0] w_in;
    logic signed [AW-1:0]      w_in_ext;
    logic signed [AW-1:0]      w_acc_nx;
    logic signed [AW-1:0]      w_avg;
    logic signed [PSUM_BW-1:0] w_res;
    logic signed [AW-1:0]      r_acc;

    assign w_in     = in_data[c*PSUM_BW +: PSUM_BW];
    assign w_in_ext = {{LW{w_in[PSUM_BW-1]}}, w_in};

    // First element loads; later elements fold in with the group's latched mode.
    always_comb begin
      w_acc_nx = r_acc;
      if (w_first) begin
        w_acc_nx = w_in_ext;
      end else if (r_mode_q) begin
        w_acc_nx = r_acc + w_in_ext;
      end else if (w_in_ext > r_acc) begin
        w_acc_nx = w_in_ext;
      end
    end

    // Average divides by WIN via arithmetic shift, i.e. floor toward -inf.
    assign w_avg = w_acc_nx >>> LW;

    // Select the column result for the completing group.
    always_comb begin
      w_res = r_mode_q ? w_avg[PSUM_BW-1:0] : w_acc_nx[PSUM_BW-1:0];
`ifdef POOL2D_GEN_RELU_EN
      if (w_res[PSUM_BW-1]) begin
        w_res = '0;
      end
`endif
    end

    assign w_result[c*PSUM_BW +: PSUM_BW] = w_res;

    // Accumulator register; clear discards the partial sum/max.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_acc <= '0;
      end else if (clear) begin
        r_acc <= '0;
      end else if (in_valid) begin
        r_acc <= w_acc_nx;
      end
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_grp       <= '0;
      r_mode_q    <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_grp   <= '0;
    end else begin
      r_cnt       <= w_cnt_next;
      r_grp       <= w_grp_next;
      r_busy      <= (w_cnt_next != '0);
      r_out_valid <= w_accept & w_last;
      if (w_accept && w_first) begin
        r_mode_q <= mode;
      end
      if (w_accept && w_last) begin
        r_out_data <= w_result;
        r_out_grp  <= r_grp;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_grp   = r_out_grp;
  assign busy      = r_busy;

endmodule

// File: tb/tb_pool2d_gen.sv
// tb_pool2d_gen: directed bench for pool2d_gen with a group-level reference model.
module tb_pool2d_gen;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int WIN     = 4;
  localparam int NGRP    = 4;
  localparam int GW      = 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic [PSUM_BW*COL-1:0] in_data = '0;
  logic                   mode = 1'b0;
  logic                   clear = 1'b0;
  logic                   out_valid;
  logic [PSUM_BW*COL-1:0] out_data;
  logic [GW-1:0]          out_grp;
  logic                   busy;

  pool2d_gen #(.PSUM_BW(PSUM_BW), .COL(COL), .WIN(WIN), .NGRP(NGRP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .mode(mode), .clear(clear), .out_valid(out_valid), .out_data(out_data),
    .out_grp(out_grp), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: collect a group's elements, pool them with integer maths.
  int elems[WIN][COL];
  int n_el = 0;
  int m_grp = 0;
  bit m_mode = 1'b0;
  bit exp_v = 1'b0;
  int exp_d[COL];
  int exp_g = 0;

  function automatic int pool_col(int c);
    int r;
    int s;
    if (!m_mode) begin
      r = elems[0][c];
      for (int i = 1; i < WIN; i++) if (elems[i][c] > r) r = elems[i][c];
    end else begin
      s = 0;
      for (int i = 0; i < WIN; i++) s += elems[i][c];
      r = s / WIN;
      if ((s % WIN) != 0 && s < 0) r -= 1;
    end
`ifdef POOL2D_GEN_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    exp_v = 1'b0;
    if (reset) begin
      n_el = 0;
      m_grp = 0;
      exp_g = 0;
      for (int c = 0; c < COL; c++) exp_d[c] = 0;
    end else if (clear) begin
      n_el = 0;
      m_grp = 0;
    end else if (in_valid) begin
      if (n_el == 0) m_mode = mode;
      for (int c = 0; c < COL; c++) elems[n_el][c] = int'($signed(in_data[c*PSUM_BW +: PSUM_BW]));
      n_el++;
      if (n_el == WIN) begin
        for (int c = 0; c < COL; c++) exp_d[c] = pool_col(c);
        exp_g = m_grp;
        exp_v = 1'b1;
        m_grp = (m_grp + 1) % NGRP;
        n_el = 0;
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the model.
  int pulses = 0;
  int cap0 = 0;
  int capg = 0;
  int grp_seq[$];

  always @(negedge clk) begin
    chk("out_valid", int'(out_valid), int'(exp_v));
    chk("busy", int'(busy), int'(n_el != 0));
    chk("out_grp", int'(out_grp), exp_g);
    for (int c = 0; c < COL; c++)
      chk($sformatf("out_data_col%0d", c), int'($signed(out_data[c*PSUM_BW +: PSUM_BW])), exp_d[c]);
    if (out_valid) begin
      pulses++;
      cap0 = int'($signed(out_data[PSUM_BW-1:0]));
      capg = int'(out_grp);
      grp_seq.push_back(capg);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    clear = 1'b0;
    repeat (n) tick();
  endtask

  task automatic put(input bit m, input int v0, input bit clr);
    logic [PSUM_BW*COL-1:0] d;
    d[PSUM_BW-1:0] = PSUM_BW'(v0);
    for (int c = 1; c < COL; c++)
      d[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(int'($urandom_range(0, 2000)) - 1000);
    in_valid = 1'b1;
    mode = m;
    clear = clr;
    in_data = d;
    tick();
    in_valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic group(input bit m, input int a, input int b, input int c, input int e);
    put(m, a, 1'b0);
    put(m, b, 1'b0);
    put(m, c, 1'b0);
    put(m, e, 1'b0);
  endtask

  int p0;

  initial begin
    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data_zero", int'(out_data != '0), 0);
    chk("rst_busy", int'(busy), 0);
    idle(2);

    // Max pooling, latency one cycle after the last element
    group(1'b0, 3, -7, 12, 5);
    chk("max_valid_now", int'(out_valid), 1);
    chk("max_col0", cap0, 12);
    chk("max_grp", capg, 0);
    idle(2);

    // Average pooling, including floor toward -inf
    group(1'b1, 4, 5, 6, -3);
    chk("avg_col0", cap0, 3);
    chk("avg_grp", capg, 1);
    idle(1);
    group(1'b1, -1, 0, 0, 0);
`ifdef POOL2D_GEN_RELU_EN
    chk("avg_floor_col0", cap0, 0);
`else
    chk("avg_floor_col0", cap0, -1);
`endif
    idle(1);

    // Frame wrap: five back-to-back groups after a clear
    put(1'b0, 0, 1'b1);
    grp_seq.delete();
    p0 = pulses;
    for (int g = 0; g < 5; g++) group(1'b0, g, 1, 2, 3);
    idle(2);
    chk("wrap_pulses", pulses - p0, 5);
    chk("wrap_seq_len", grp_seq.size(), 5);
    if (grp_seq.size() == 5) begin
      chk("wrap_g0", grp_seq[0], 0);
      chk("wrap_g1", grp_seq[1], 1);
      chk("wrap_g2", grp_seq[2], 2);
      chk("wrap_g3", grp_seq[3], 3);
      chk("wrap_g4", grp_seq[4], 0);
    end

    // Mid-group mode toggle ignored, with 3-cycle gaps
    put(1'b0, 1, 1'b0); idle(3);
    put(1'b1, 9, 1'b0); idle(3);
    put(1'b1, 2, 1'b0); idle(3);
    put(1'b1, 2, 1'b0);
    chk("toggle_col0", cap0, 9);
    idle(2);

    // Clear together with in_valid after two elements
    put(1'b1, 100, 1'b0);
    put(1'b1, 200, 1'b0);
    p0 = pulses;
    put(1'b1, 300, 1'b1);
    chk("clear_busy", int'(busy), 0);
    group(1'b1, 8, 8, 8, 8);
    chk("clear_col0", cap0, 8);
    chk("clear_grp", capg, 0);
    chk("clear_one_pulse", pulses - p0, 1);
    idle(1);

    // Mode toggles on the completing element; accumulator width extremes
    put(1'b0, 4, 1'b0); put(1'b0, 7, 1'b0); put(1'b0, 2, 1'b0); put(1'b1, 1, 1'b0);
    chk("last_toggle_col0", cap0, 7);
    group(1'b1, 32767, 32767, 32767, 32767);
    chk("avg_pos_ext_col0", cap0, 32767);
    group(1'b1, -32768, -32768, -32768, -32768);
`ifdef POOL2D_GEN_RELU_EN
    chk("avg_neg_ext_col0", cap0, 0);
`else
    chk("avg_neg_ext_col0", cap0, -32768);
`endif
    group(1'b1, -1, -1, -1, -2);
`ifdef POOL2D_GEN_RELU_EN
    chk("avg_neg_floor_col0", cap0, 0);
`else
    chk("avg_neg_floor_col0", cap0, -2);
`endif
    idle(1);

    // ReLU option on a negative max
    group(1'b0, -5, -2, -9, -1);
`ifdef POOL2D_GEN_RELU_EN
    chk("relu_col0", cap0, 0);
`else
    chk("relu_col0", cap0, -1);
`endif
    idle(1);

    // Reset mid-group overrides clear and in_valid
    put(1'b0, 50, 1'b0);
    put(1'b0, 60, 1'b0);
    put(1'b0, 70, 1'b0);
    p0 = pulses;
    reset = 1'b1;
    put(1'b0, 80, 1'b1);
    reset = 1'b0;
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_data_zero", int'(out_data != '0), 0);
    chk("rst_mid_grp", int'(out_grp), 0);
    chk("rst_mid_busy", int'(busy), 0);
    idle(4);
    chk("rst_mid_no_pulse", pulses - p0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pool2d_gen.md
POOL2D_GEN -- requirements
Module: pool2d_gen

Interface
REQ-001 SHALL have parameter PSUM_BW, default 16, signed element width per column.
REQ-002 SHALL have parameter COL, default 8, number of parallel columns.
REQ-003 SHALL have parameter WIN, default 4, elements per pooling group; power of two, 2..16.
REQ-004 SHALL have parameter NGRP, default 4, groups per frame; out_grp width GW = max(1, clog2(NGRP)).
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  in_data carries one window element this cycle.
REQ-008 SHALL have port in_data  input  PSUM_BW*COL  column i in bits [i*PSUM_BW +: PSUM_BW], signed.
REQ-009 SHALL have port mode  input  1  0 = max pooling, 1 = average pooling.
REQ-010 SHALL have port clear  input  1  synchronous abort of the partial group and frame.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse, pooled result present.
REQ-012 SHALL have port out_data  output  PSUM_BW*COL  pooled result, same column packing as in_data.
REQ-013 SHALL have port out_grp  output  GW  index of the group that produced out_data.
REQ-014 SHALL have port busy  output  1  high while a group is partially accumulated (cnt != 0).

Function
REQ-015 SHALL keep element counter cnt (0..WIN-1), advancing only on accepted in_valid; wrap WIN-1 -> 0.
REQ-016 SHALL keep group counter grp (0..NGRP-1), advancing when cnt wraps; wrap NGRP-1 -> 0.
REQ-017 SHALL latch mode into mode_q when in_valid with cnt==0; mode changes mid-group SHALL be ignored until the next group.
REQ-018 SHALL hold per-column accumulator acc of width PSUM_BW+clog2(WIN), sign-extended.
REQ-019 SHALL load acc with sign-extended in_data on in_valid with cnt==0, irrespective of mode.
REQ-020 SHALL, on in_valid with cnt!=0, set acc to signed max(acc, in) when mode_q=0, or acc+in when mode_q=1.
REQ-021 SHALL, on in_valid with cnt==WIN-1, register the final group value into out_data and assert out_valid in the next cycle (latency 1 from the last element).
REQ-022 SHALL produce avg result as arithmetic right shift of the full sum by clog2(WIN) (floor toward -inf), truncated to PSUM_BW; max result as the PSUM_BW signed max.
REQ-023 SHALL drive out_grp with grp value of the completed group, registered with out_data.
REQ-024 SHALL hold out_data and out_grp stable when out_valid is low; out_valid SHALL be high for exactly one cycle per completed group.
REQ-025 SHALL tolerate arbitrary gaps between in_valid cycles without altering results.
REQ-026 SHALL, on clear, set cnt=0, grp=0 and discard acc in the same edge; clear SHALL take priority over a simultaneous in_valid (element dropped); an out_valid already scheduled from the preceding cycle SHALL still be emitted.
REQ-027 SHALL treat in_valid with clear low and WIN==cnt+1 on the same edge as group completion even if mode toggles that cycle.

Reset
REQ-028 SHALL, on reset, force cnt=0, grp=0, mode_q=0, acc=0, out_valid=0, out_data=0, out_grp=0, busy=0.
REQ-029 SHALL, on reset mid-group, discard the partial group with no out_valid; reset SHALL override clear and in_valid.

Configuration
REQ-030 SHALL honour macro POOL2D_GEN_RELU_EN: when defined, each column result SHALL be clamped to 0 if negative before registering into out_data.
REQ-031 SHALL, without POOL2D_GEN_RELU_EN, pass signed negative results unchanged; no other behaviour SHALL differ.

Verification
REQ-032 SHALL test max: WIN=4, mode=0, col0 inputs 3,-7,12,5 -> one cycle after 4th element out_valid=1, col0=12, out_grp=0.
REQ-033 SHALL test avg: WIN=4, mode=1, col0 inputs 4,5,6,-3 (sum 12) -> col0=3; inputs -1,0,0,0 -> col0=-1 (floor).
REQ-034 SHALL test frame wrap: NGRP=4, 5 consecutive groups -> out_grp sequence 0,1,2,3,0, five single-cycle out_valid pulses.
REQ-035 SHALL test mid-group mode toggle and gaps: mode=0 at element 0, mode=1 from element 1, in_valid gaps of 3 cycles, inputs 1,9,2,2 -> col0=9.
REQ-036 SHALL test clear/reset: clear with in_valid after 2 elements, then 4 elements 8,8,8,8 avg -> col0=8, out_grp=0; reset after 3 elements -> no out_valid, all outputs 0.
REQ-037 SHALL test RELU: with POOL2D_GEN_RELU_EN, max of -5,-2,-9,-1 -> col0=0; without, col0=-1.
